// File: rtl/apb_master.sv
// Single-outstanding APB master: valid/ready host request in, held response out.
// Runs SETUP/ACCESS with slave wait states and a wait-state timeout abort.
module apb_master #(
   parameter int DW     = 32,
   parameter int AW     = 5,
   parameter int SW     = DW/8,
   parameter int TO_CYC = 16
) (
   input  logic          pclk,
   input  logic          preset,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   input  logic          i_req_write,
   input  logic [AW-1:0] i_req_addr,
   input  logic [DW-1:0] i_req_wdata,
   input  logic [SW-1:0] i_req_strb,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [DW-1:0] o_rsp_rdata,
   output logic          o_rsp_err,
   output logic          o_rsp_timeout,
   output logic [AW-1:0] o_paddr,
   output logic          o_pwrite,
   output logic          o_psel,
   output logic          o_penable,
   output logic [DW-1:0] o_pwdata,
   output logic [SW-1:0] o_pstrb,
   input  logic [DW-1:0] i_prdata,
   input  logic          i_pready,
   input  logic          i_pslverr
);

   localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
   localparam logic [CW-1:0] LIM = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_write;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [SW-1:0]   r_strb;
   logic            r_psel;
   logic            r_penable;
   logic [CW-1:0]   r_wcnt;
   logic [DW-1:0]   r_rsp_rdata;
   logic            r_rsp_err;
   logic            r_rsp_to;
   logic            w_accept;
   logic            w_done;
   logic            w_timeout;

   assign o_req_ready = (r_state == S_IDLE);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_done      = (r_state == S_ACCESS) && i_pready;
   // Abort on the TO_CYC-th consecutive not-ready ACCESS cycle
   assign w_timeout   = (TO_CYC != 0) && (r_state == S_ACCESS) &&
                        !i_pready && (r_wcnt == LIM);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_SETUP;
         S_SETUP:  w_next = S_ACCESS;
         S_ACCESS: if (w_done || w_timeout) w_next = S_RESP;
         S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_strb  <= '0;
      end else if (w_accept) begin
         r_write <= i_req_write;
         r_addr  <= i_req_addr;
         r_wdata <= i_req_write ? i_req_wdata : '0;
         r_strb  <= i_req_write ? i_req_strb : '0;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
      end else begin
         r_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
         r_penable <= (w_next == S_ACCESS);
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset)
         r_wcnt <= '0;
      else if (r_state == S_SETUP)
         r_wcnt <= '0;
      else if ((r_state == S_ACCESS) && !i_pready)
         r_wcnt <= r_wcnt + CW'(1);
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_to    <= 1'b0;
      end else if (w_done) begin
         r_rsp_rdata <= (!r_write && !i_pslverr) ? i_prdata : '0;
         r_rsp_err   <= i_pslverr;
         r_rsp_to    <= 1'b0;
      end else if (w_timeout) begin
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b1;
         r_rsp_to    <= 1'b1;
      end
   end

   assign o_paddr       = r_addr;
   assign o_pwrite      = r_write;
   assign o_pwdata      = r_wdata;
   assign o_pstrb       = r_strb;
   assign o_psel        = r_psel;
   assign o_penable     = r_penable;
   assign o_rsp_valid   = (r_state == S_RESP);
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_rsp_err     = r_rsp_err;
   assign o_rsp_timeout = r_rsp_to;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master against a transaction-level reference model.
// The APB slave model inserts a chosen number of wait states per transfer.
module tb_apb_master;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int SW = 4;
   localparam int TO = 4;

   logic          pclk;
   logic          preset;
   logic          i_req_valid;
   logic          o_req_ready;
   logic          i_req_write;
   logic [AW-1:0] i_req_addr;
   logic [DW-1:0] i_req_wdata;
   logic [SW-1:0] i_req_strb;
   logic          o_rsp_valid;
   logic          i_rsp_ready;
   logic [DW-1:0] o_rsp_rdata;
   logic          o_rsp_err;
   logic          o_rsp_timeout;
   logic [AW-1:0] o_paddr;
   logic          o_pwrite;
   logic          o_psel;
   logic          o_penable;
   logic [DW-1:0] o_pwdata;
   logic [SW-1:0] o_pstrb;
   logic [DW-1:0] i_prdata;
   logic          i_pready;
   logic          i_pslverr;

   int n_chk = 0;
   int n_err = 0;

   apb_master #(.DW(DW), .AW(AW), .SW(SW), .TO_CYC(TO)) u_dut (
      .pclk          (pclk),
      .preset        (preset),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_write   (i_req_write),
      .i_req_addr    (i_req_addr),
      .i_req_wdata   (i_req_wdata),
      .i_req_strb    (i_req_strb),
      .o_rsp_valid   (o_rsp_valid),
      .i_rsp_ready   (i_rsp_ready),
      .o_rsp_rdata   (o_rsp_rdata),
      .o_rsp_err     (o_rsp_err),
      .o_rsp_timeout (o_rsp_timeout),
      .o_paddr       (o_paddr),
      .o_pwrite      (o_pwrite),
      .o_psel        (o_psel),
      .o_penable     (o_penable),
      .o_pwdata      (o_pwdata),
      .o_pstrb       (o_pstrb),
      .i_prdata      (i_prdata),
      .i_pready      (i_pready),
      .i_pslverr     (i_pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One host transfer; waits >= TO means the slave never answers in time.
   task automatic xfer(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       input int waits, input logic serr,
                       input logic [DW-1:0] rd, input int hold,
                       input logic pend);
      logic          to;
      logic          e_err;
      logic [DW-1:0] e_rd;
      logic [DW-1:0] e_wd;
      logic [SW-1:0] e_st;
      int            n_acc;
      int            lat;
      int            ps;
      int            pe;
      to    = (waits >= TO);
      n_acc = to ? TO : waits + 1;
      e_err = to ? 1'b1 : serr;
      e_rd  = (!to && !wr && !serr) ? rd : '0;
      e_wd  = wr ? wd : '0;
      e_st  = wr ? st : '0;
      i_req_valid = 1'b1;
      i_req_write = wr;
      i_req_addr  = a;
      i_req_wdata = wd;
      i_req_strb  = st;
      check("req_ready", o_req_ready, 1);
      @(posedge pclk); #1;
      i_req_valid = 1'b0;
      i_req_wdata = $urandom;
      i_req_strb  = SW'($urandom);
      lat = 1;
      ps  = 0;
      pe  = 0;
      while (!o_rsp_valid && lat < 100) begin
         if (o_psel) begin
            ps++;
            check("paddr", o_paddr, a);
            check("pwrite", o_pwrite, wr);
            check("pwdata", o_pwdata, e_wd);
            check("pstrb", o_pstrb, e_st);
            check("penable", o_penable, ps > 1);
         end else begin
            check("psel_busy", o_psel, 1);
         end
         if (o_psel && o_penable) begin
            pe++;
            i_pready  = (pe - 1 == waits);
            i_pslverr = i_pready ? serr : 1'($urandom);
            i_prdata  = i_pready ? rd : $urandom;
         end else begin
            i_pready = 1'b0;
         end
         @(posedge pclk); #1;
         lat++;
      end
      i_pready = 1'b0;
      check("rsp_valid", o_rsp_valid, 1);
      check("latency", lat, to ? 2 + TO : 3 + waits);
      check("psel_cycles", ps, n_acc + 1);
      check("pen_cycles", pe, n_acc);
      check("rsp_err", o_rsp_err, e_err);
      check("rsp_to", o_rsp_timeout, to);
      check("rsp_rdata", o_rsp_rdata, e_rd);
      check("psel_resp", o_psel, 0);
      i_rsp_ready = 1'b0;
      if (pend) i_req_valid = 1'b1;
      repeat (hold) begin
         @(posedge pclk); #1;
         check("hold_valid", o_rsp_valid, 1);
         check("hold_err", o_rsp_err, e_err);
         check("hold_rdata", o_rsp_rdata, e_rd);
         check("hold_ready", o_req_ready, 0);
         check("hold_psel", o_psel, 0);
      end
      i_rsp_ready = 1'b1;
      @(posedge pclk); #1;
      i_rsp_ready = 1'b0;
      check("rsp_done", o_rsp_valid, 0);
      check("idle_ready", o_req_ready, 1);
      check("idle_psel", o_psel, 0);
   endtask

   initial begin
      preset      = 1'b1;
      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_addr  = 5'h08;
      i_req_wdata = 32'h1;
      i_req_strb  = 4'hF;
      i_rsp_ready = 1'b0;
      i_prdata    = '0;
      i_pready    = 1'b0;
      i_pslverr   = 1'b0;
      #1;
      check("rst_ready", o_req_ready, 1);
      check("rst_psel", o_psel, 0);
      check("rst_pen", o_penable, 0);
      check("rst_rsp", o_rsp_valid, 0);
      check("rst_paddr", o_paddr, 0);
      repeat (2) @(posedge pclk);
      #1;
      check("rst_noacc", o_psel, 0);
      check("rst_err", o_rsp_err, 0);
      i_req_valid = 1'b0;
      @(negedge pclk);
      preset = 1'b0;

      xfer(1, 5'h08, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 0, 0);
      xfer(0, 5'h0C, 32'h5555_AAAA, 4'hF, 2, 0, 32'hDEAD_BEEF, 0, 0);
      xfer(0, 5'h04, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, 0, 0);
      xfer(0, 5'h10, 32'h0, 4'h0, 99, 0, 32'h1111_2222, 0, 0);
      xfer(0, 5'h14, 32'h0, 4'h0, 3, 0, 32'h3333_4444, 0, 0);
      xfer(1, 5'h18, 32'hA5A5_5A5A, 4'h3, 1, 0, 32'h0, 0, 0);
      xfer(0, 5'h1C, 32'h0, 4'h0, 1, 0, 32'h7777_8888, 5, 1);
      xfer(1, 5'h00, 32'h0BAD_F00D, 4'h9, 0, 0, 32'h0, 0, 0);

      i_req_valid = 1'b1;
      i_req_write = 1'b1;
      i_req_addr  = 5'h10;
      i_req_wdata = 32'hFEED_0001;
      i_req_strb  = 4'hF;
      @(posedge pclk); #1;
      i_req_valid = 1'b0;
      i_pready    = 1'b0;
      @(posedge pclk); #1;
      check("pre_rst_psel", o_psel, 1);
      check("pre_rst_pen", o_penable, 1);
      preset = 1'b1;
      #1;
      check("mid_rst_psel", o_psel, 0);
      check("mid_rst_pen", o_penable, 0);
      check("mid_rst_ready", o_req_ready, 1);
      repeat (3) begin
         @(posedge pclk); #1;
         check("mid_rst_rsp", o_rsp_valid, 0);
      end
      @(negedge pclk);
      preset = 1'b0;
      #1;
      check("post_rst_rsp", o_rsp_valid, 0);
      xfer(1, 5'h0C, 32'h0102_0304, 4'hF, 0, 0, 32'h0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         xfer(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
              $urandom_range(0, 5), 1'($urandom_range(0, 3) == 0),
              $urandom, $urandom_range(0, 3), 1'($urandom));
      end
      i_req_valid = 1'b0;
      repeat (2) @(posedge pclk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB master bridge that sits directly upstream of the register-map APB slaves. It accepts one request at a time from a valid/ready host port and runs the APB SETUP and ACCESS phases, honouring slave wait states. It returns read data and error status on a held response port, and aborts any transfer whose ACCESS phase exceeds a programmable wait-state limit.

## Interface
Parameters:
- DW, 32, data width (multiple of 8)
- AW, 5, address width (max 32)
- SW, DW/8, strobe width (derived)
- TO_CYC, 16, max consecutive ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
- pclk  in  1  clock
- preset  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  host request valid
- o_req_ready  out  1  host request ready
- i_req_write  in  1  1 = write, 0 = read
- i_req_addr  in  AW  byte address
- i_req_wdata  in  DW  write data
- i_req_strb  in  SW  write byte strobes
- o_rsp_valid  out  1  response valid, held until taken
- i_rsp_ready  in  1  host takes response
- o_rsp_rdata  out  DW  read data
- o_rsp_err  out  1  slave error or timeout
- o_rsp_timeout  out  1  transfer aborted by timeout
- o_paddr  out  AW  APB address
- o_pwrite  out  1  APB direction
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwdata  out  DW  APB write data
- o_pstrb  out  SW  APB strobes
- i_prdata  in  DW  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

## Operation
- FSM states and transitions:
  - IDLE: on i_req_valid && o_req_ready, go to SETUP.
  - SETUP: always go to ACCESS.
  - ACCESS: on i_pready, go to RESP. On timeout, go to RESP.
  - RESP: on i_rsp_ready, go to IDLE.
- Request acceptance and ready:
  - o_req_ready = (state == IDLE), combinational. There is no request acceptance in any other state.
  - On accept, capture addr, write, wdata and strb into holding registers.
  - For reads, force the captured wdata and strb to 0.
- APB outputs are registered and driven from the holding registers:
  - SETUP: o_psel = 1, o_penable = 0.
  - ACCESS: o_psel = 1, o_penable = 1.
  - All other states: o_psel = 0, o_penable = 0.
  - o_paddr, o_pwrite, o_pwdata and o_pstrb stay stable from SETUP through the last ACCESS cycle.
- Wait counter:
  - Cleared on entry to ACCESS.
  - Increments every ACCESS cycle with i_pready = 0.
  - Width is $clog2(TO_CYC+1).
  - Timeout fires when i_pready = 0 on the TO_CYC-th consecutive ACCESS cycle (TO_CYC ≠ 0).
- Response capture (registered) on ACCESS exit:
  - Normal completion: o_rsp_err = i_pslverr.
  - o_rsp_rdata = i_prdata only if read and !i_pslverr; otherwise 0.
  - Timeout: o_rsp_err = 1, o_rsp_timeout = 1, o_rsp_rdata = 0.
- o_rsp_valid = 1 in RESP. The rsp_* fields are held stable until the i_rsp_ready handshake.
- i_pslverr and i_prdata are ignored unless i_pready = 1 in ACCESS.

## Timing
- Let E0 be the clock edge where the request is accepted. With zero wait states:
  - SETUP occupies the cycle after E0.
  - ACCESS follows; i_pready is sampled at E2.
  - o_rsp_valid is high after E2, i.e. minimum request-to-response latency is 3 cycles.
- Each slave wait state adds 1 cycle.
- Zero-wait compatibility: a slave that registers pready high in the cycle after it sees psel completes in exactly one ACCESS cycle.
- Back-to-back requests: after the RESP handshake at edge En, IDLE is in the cycle after En. The next accept is at En+1 at the earliest, so there are 4 cycles per transfer minimum.
- Response backpressure: while in RESP, o_req_ready = 0 and the APB bus is idle.
- Reset values (async on preset):
  - State = IDLE; all APB outputs and all rsp_* outputs = 0.
  - o_req_ready reads 1, but no request is accepted while preset = 1.
- Reset mid-transfer: o_psel and o_penable fall immediately (asynchronously). The in-flight transfer is dropped and no response is produced.
- Timeout boundary:
  - i_pready = 1 on the TO_CYC-th ACCESS cycle counts as normal completion, not timeout.
  - TO_CYC = 0 means ACCESS waits indefinitely.

## Test plan
- Write, zero wait, addr 0x08, data 0x1234_5678, strb 0xF:
  - o_psel high 2 cycles, o_penable high 1 cycle, o_pstrb = 0xF.
  - o_rsp_valid 3 cycles after accept; err = 0, rdata = 0.
- Read addr 0x0C, slave inserts 2 wait states, i_prdata = 0xDEAD_BEEF:
  - o_penable high 3 cycles, o_pstrb = 0, o_pwdata = 0.
  - o_rsp_rdata = 0xDEAD_BEEF, err = 0, latency 5.
- Read addr 0x04 with i_pslverr = 1 at completion:
  - o_rsp_err = 1, o_rsp_timeout = 0, o_rsp_rdata = 0.
- TO_CYC = 4, i_pready stuck 0:
  - ACCESS lasts exactly 4 cycles, then o_psel drops.
  - o_rsp_err = 1, o_rsp_timeout = 1, rdata = 0.
  - A later request completes normally.
- Hold i_rsp_ready = 0 for 5 cycles after a read, with a second request already pending:
  - Response fields stay stable and o_req_ready stays 0.
  - The second request is accepted exactly 1 cycle after the response handshake.
- Assert preset during ACCESS of a write:
  - o_psel and o_penable = 0 in the same cycle; o_rsp_valid never rises.
  - After release, o_req_ready = 1 and a new write completes normally.
